// File: rtl/batalha_pkg.sv
// Shared encodings for the battleship attack engine:
// operating-mode codes, shot result codes and FSM states.
package batalha_pkg;

  localparam logic [1:0] EST_DESLIGADO  = 2'b00;
  localparam logic [1:0] EST_PREPARACAO = 2'b01;
  localparam logic [1:0] EST_ATAQUE     = 2'b10;

  localparam logic [2:0] RES_NENHUM   = 3'd0;
  localparam logic [2:0] RES_ACERTO   = 3'd1;
  localparam logic [2:0] RES_ERRO     = 3'd2;
  localparam logic [2:0] RES_REPETIDO = 3'd3;
  localparam logic [2:0] RES_INVALIDO = 3'd4;

  typedef enum logic [2:0] {
    OCIOSO,
    CONTA,
    PRONTO,
    AVALIA,
    VITORIA,
    DERROTA
  } fsm_e;

endpackage

// File: rtl/gerenciador_ataque_nxm_contador_navios.sv
// Serial ship-cell scanner: after start, walks one map cell
// per cycle and accumulates the number of set bits.
module contador_navios #(
  parameter int N   = 35,
  parameter int W_N = 6
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           start,
  input  logic [N-1:0]   mapa,
  output logic           done,
  output logic [W_N-1:0] count
);

  localparam int W_I = (N > 1) ? $clog2(N) : 1;

  logic           busy_q, busy_d;
  logic [W_I-1:0] idx_q, idx_d;
  logic [W_N-1:0] cnt_q, cnt_d;
  logic [N-1:0]   desl;
  logic           bit_atual;

  always_comb begin
    desl      = mapa >> idx_q;
    bit_atual = desl[0] & busy_q;
    // count already includes the cell under scan this cycle
    count     = cnt_q + W_N'(bit_atual);
    done      = busy_q && (idx_q == W_I'(N - 1));
    busy_d    = busy_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    if (busy_q) begin
      cnt_d = count;
      idx_d = idx_q + W_I'(1);
      if (done) busy_d = 1'b0;
    end else if (start) begin
      busy_d = 1'b1;
      idx_d  = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      idx_q  <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/gerenciador_ataque_nxm.sv
// Parametrised battleship attack engine: holds the map,
// counts ships, evaluates shots and declares win or loss.
module gerenciador_ataque_nxm
  import batalha_pkg::*;
#(
  parameter int LINHAS  = 7,
  parameter int COLUNAS = 5,
  parameter int VIDAS   = 3,
  localparam int N   = LINHAS * COLUNAS,
  localparam int W_V = $clog2(VIDAS + 1),
  localparam int W_N = $clog2(N + 1)
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic [1:0]     estado,
  input  logic           carregar,
  input  logic [N-1:0]   mapa_in,
  input  logic           confirmar,
  input  logic [2:0]     linha,
  input  logic [2:0]     coluna,
  output logic [N-1:0]   acertos,
  output logic [N-1:0]   erros,
  output logic [W_V-1:0] vida,
  output logic [W_N-1:0] restantes,
  output logic [2:0]     resultado,
  output logic           resultado_ok,
  output logic           LED_R,
  output logic           LED_G,
  output logic           LED_B,
  output logic           fim_jogo,
  output logic           vitoria,
  output logic           ocupado
);

  localparam logic [N-1:0] UM = N'(1);

  fsm_e           st_q, st_d;
  logic [N-1:0]   mapa_q, mapa_d;
  logic [N-1:0]   ac_q, ac_d;
  logic [N-1:0]   er_q, er_d;
  logic [W_V-1:0] vida_q, vida_d;
  logic [W_N-1:0] rest_q, rest_d;
  logic           scan_ok_q, scan_ok_d;
  logic [2:0]     lin_q, lin_d;
  logic [2:0]     col_q, col_d;
  logic [2:0]     res_q, res_d;
  logic           ok_q, ok_d;
  logic           lr_q, lr_d;
  logic           lg_q, lg_d;
  logic           lb_q, lb_d;
  logic           fim_q, fim_d;
  logic           vit_q, vit_d;
  logic           ocp_q, ocp_d;

  logic           iniciar;
  logic           cont_done;
  logic [W_N-1:0] cont_count;
  logic           desligado;
  logic           fora;
  logic [6:0]     pos;
  logic [N-1:0]   sel;

  contador_navios #(
    .N   (N),
    .W_N (W_N)
  ) u_contador (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (iniciar),
    .mapa    (mapa_q),
    .done    (cont_done),
    .count   (cont_count)
  );

  always_comb begin
    desligado = (estado != EST_PREPARACAO)
             && (estado != EST_ATAQUE);
    fora = ({1'b0, lin_q} >= 4'(LINHAS))
        || ({1'b0, col_q} >= 4'(COLUNAS));
    pos  = 7'(col_q) * 7'(LINHAS) + 7'(lin_q);
    sel  = UM << pos;

    st_d      = st_q;
    mapa_d    = mapa_q;
    ac_d      = ac_q;
    er_d      = er_q;
    vida_d    = vida_q;
    rest_d    = rest_q;
    scan_ok_d = scan_ok_q;
    lin_d     = lin_q;
    col_d     = col_q;
    res_d     = res_q;
    ok_d      = 1'b0;
    lr_d      = lr_q;
    lg_d      = lg_q;
    lb_d      = lb_q;
    iniciar   = 1'b0;

    // a running scan always completes before mode changes act
    if (desligado && st_q != CONTA) begin
      st_d      = OCIOSO;
      ac_d      = '0;
      er_d      = '0;
      vida_d    = W_V'(VIDAS);
      rest_d    = '0;
      scan_ok_d = 1'b0;
      res_d     = RES_NENHUM;
      lr_d      = 1'b0;
      lg_d      = 1'b0;
      lb_d      = 1'b0;
    end else begin
      unique case (st_q)
        OCIOSO: begin
          if (estado == EST_PREPARACAO && carregar) begin
            mapa_d    = mapa_in;
            ac_d      = '0;
            er_d      = '0;
            rest_d    = '0;
            vida_d    = W_V'(VIDAS);
            scan_ok_d = 1'b0;
            iniciar   = 1'b1;
            st_d      = CONTA;
          end else if (estado == EST_ATAQUE && scan_ok_q) begin
            st_d = (rest_q == '0) ? VITORIA : PRONTO;
          end
        end
        CONTA: begin
          rest_d = cont_count;
          if (cont_done) begin
            scan_ok_d = 1'b1;
            st_d      = OCIOSO;
          end
        end
        PRONTO: begin
          if (estado == EST_PREPARACAO) begin
            st_d = OCIOSO;
          end else if (confirmar) begin
            lin_d = linha;
            col_d = coluna;
            st_d  = AVALIA;
          end
        end
        AVALIA: begin
          st_d = PRONTO;
          ok_d = 1'b1;
          if (fora) begin
            res_d = RES_INVALIDO;
          end else if (|((ac_q | er_q) & sel)) begin
            res_d = RES_REPETIDO;
          end else if (|(mapa_q & sel)) begin
            res_d  = RES_ACERTO;
            ac_d   = ac_q | sel;
            rest_d = rest_q - W_N'(1);
            if (rest_q == W_N'(1)) st_d = VITORIA;
          end else begin
            res_d  = RES_ERRO;
            er_d   = er_q | sel;
            vida_d = vida_q - W_V'(1);
            if (vida_q == W_V'(1)) st_d = DERROTA;
          end
          lg_d = (res_d == RES_ACERTO);
          lr_d = (res_d == RES_ERRO);
          lb_d = (res_d == RES_REPETIDO)
              || (res_d == RES_INVALIDO);
        end
        VITORIA, DERROTA: begin
          if (estado == EST_PREPARACAO) st_d = OCIOSO;
        end
        default: st_d = OCIOSO;
      endcase
    end

    fim_d = (st_d == VITORIA) || (st_d == DERROTA);
    vit_d = (st_d == VITORIA);
    ocp_d = (st_d == CONTA) || (st_d == AVALIA);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st_q      <= OCIOSO;
      mapa_q    <= '0;
      ac_q      <= '0;
      er_q      <= '0;
      vida_q    <= W_V'(VIDAS);
      rest_q    <= '0;
      scan_ok_q <= 1'b0;
      lin_q     <= '0;
      col_q     <= '0;
      res_q     <= RES_NENHUM;
      ok_q      <= 1'b0;
      lr_q      <= 1'b0;
      lg_q      <= 1'b0;
      lb_q      <= 1'b0;
      fim_q     <= 1'b0;
      vit_q     <= 1'b0;
      ocp_q     <= 1'b0;
    end else begin
      st_q      <= st_d;
      mapa_q    <= mapa_d;
      ac_q      <= ac_d;
      er_q      <= er_d;
      vida_q    <= vida_d;
      rest_q    <= rest_d;
      scan_ok_q <= scan_ok_d;
      lin_q     <= lin_d;
      col_q     <= col_d;
      res_q     <= res_d;
      ok_q      <= ok_d;
      lr_q      <= lr_d;
      lg_q      <= lg_d;
      lb_q      <= lb_d;
      fim_q     <= fim_d;
      vit_q     <= vit_d;
      ocp_q     <= ocp_d;
    end
  end

  assign acertos      = ac_q;
  assign erros        = er_q;
  assign vida         = vida_q;
  assign restantes    = rest_q;
  assign resultado    = res_q;
  assign resultado_ok = ok_q;
  assign LED_R        = lr_q;
  assign LED_G        = lg_q;
  assign LED_B        = lb_q;
  assign fim_jogo     = fim_q;
  assign vitoria      = vit_q;
  assign ocupado      = ocp_q;

endmodule

// File: tb/tb_gerenciador_ataque_nxm.sv
// Directed bench: default 7x5x3 engine plus an 8x8x7
// instance for full-grid scan and corner-cell checks.
module tb_gerenciador_ataque_nxm;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset_n;

  logic [1:0]  est;
  logic        carr, conf;
  logic [2:0]  lin, col;
  logic [34:0] mapa, ac, er;
  logic [1:0]  vida;
  logic [5:0]  rest;
  logic [2:0]  res;
  logic        ok, lr, lg, lb, fim, vit, ocp;

  logic [1:0]  est8;
  logic        carr8, conf8;
  logic [2:0]  lin8, col8;
  logic [63:0] mapa8, ac8, er8;
  logic [2:0]  vida8;
  logic [6:0]  rest8;
  logic [2:0]  res8;
  logic        ok8, lr8, lg8, lb8, fim8, vit8, ocp8;

  int n_chk = 0;
  int n_err = 0;

  gerenciador_ataque_nxm dut (
    .clock(clock), .reset_n(reset_n), .estado(est),
    .carregar(carr), .mapa_in(mapa), .confirmar(conf),
    .linha(lin), .coluna(col), .acertos(ac), .erros(er),
    .vida(vida), .restantes(rest), .resultado(res),
    .resultado_ok(ok), .LED_R(lr), .LED_G(lg), .LED_B(lb),
    .fim_jogo(fim), .vitoria(vit), .ocupado(ocp)
  );

  gerenciador_ataque_nxm #(
    .LINHAS(8), .COLUNAS(8), .VIDAS(7)
  ) dut8 (
    .clock(clock), .reset_n(reset_n), .estado(est8),
    .carregar(carr8), .mapa_in(mapa8), .confirmar(conf8),
    .linha(lin8), .coluna(col8), .acertos(ac8), .erros(er8),
    .vida(vida8), .restantes(rest8), .resultado(res8),
    .resultado_ok(ok8), .LED_R(lr8), .LED_G(lg8), .LED_B(lb8),
    .fim_jogo(fim8), .vitoria(vit8), .ocupado(ocp8)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic tiro(input logic [2:0] l, input logic [2:0] c);
    lin  = l;
    col  = c;
    conf = 1'b1;
    tick();
    conf = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    est = 2'b00; carr = 0; conf = 0; lin = 0; col = 0; mapa = '0;
    est8 = 2'b00; carr8 = 0; conf8 = 0; lin8 = 0; col8 = 0;
    mapa8 = '0;
    tick(); tick();
    chk("rst_vida", vida, 3);
    chk("rst_rest", rest, 0);
    chk("rst_res", res, 0);
    chk("rst_ac", ac, 0);
    chk("rst_leds", {lr, lg, lb, ok}, 0);
    chk("rst_flags", {fim, vit, ocp}, 0);
    reset_n = 1'b1;

    // attack without any load stays idle
    est = 2'b10;
    repeat (3) tick();
    chk("noload_fim", fim, 0);
    tiro(0, 0); tick();
    chk("noload_ok", ok, 0);

    // empty map wins straight away
    est = 2'b01; mapa = '0; carr = 1; tick(); carr = 0;
    repeat (36) tick();
    est = 2'b10; repeat (2) tick();
    chk("vazio_vit", vit, 1);

    // load ships at (0,0) and (1,0)
    est = 2'b01; tick();
    mapa = 35'h3; carr = 1; tick(); carr = 0;
    chk("conta_ocp0", ocp, 1);
    mapa = '1; carr = 1; tick(); carr = 0;
    repeat (33) tick();
    chk("conta_ocp35", ocp, 1);
    tick();
    chk("conta_fim", ocp, 0);
    chk("conta_rest", rest, 2);

    est = 2'b10; repeat (2) tick();
    tiro(0, 0); tick();
    chk("hit_res", res, 1);
    chk("hit_ok", ok, 1);
    chk("hit_leds", {lr, lg, lb}, 3'b010);
    chk("hit_rest", rest, 1);
    chk("hit_ac", ac, 1);
    tick();
    chk("hit_ok_pulse", ok, 0);
    chk("hit_ledg_hold", lg, 1);

    tiro(3, 2); tick();
    chk("miss_res", res, 2);
    chk("miss_vida", vida, 2);
    chk("miss_er", er, 64'h20000);
    chk("miss_leds", {lr, lg, lb}, 3'b100);

    tiro(3, 2); tick();
    chk("rep_res", res, 3);
    chk("rep_vida", vida, 2);
    chk("rep_ledb", lb, 1);

    tiro(7, 0);
    lin = 1; col = 0; conf = 1; tick(); conf = 0;
    chk("inv_res", res, 4);
    chk("inv_ok", ok, 1);
    chk("inv_leds", {lr, lg, lb}, 3'b001);
    tick();
    chk("drop_rest", rest, 1);
    chk("drop_ac", ac, 1);
    chk("drop_ok", ok, 0);

    tiro(4, 2); tick();
    chk("miss2_vida", vida, 1);
    tiro(5, 2);
    chk("derrota_pre", fim, 0);
    tick();
    chk("derrota_vida", vida, 0);
    chk("derrota_flags", {fim, vit}, 2'b10);
    chk("derrota_er", er, 64'hE0000);
    tiro(1, 0); tick(); tick();
    chk("derrota_ign_rest", rest, 1);
    chk("derrota_ign_ok", ok, 0);

    // new game on same map, win it
    est = 2'b01; tick();
    mapa = 35'h3; carr = 1; tick(); carr = 0;
    chk("reload_vida", vida, 3);
    chk("reload_er", er, 0);
    chk("reload_ac", ac, 0);
    repeat (35) tick();
    est = 2'b10; repeat (2) tick();
    tiro(0, 0); tick();
    chk("win1_rest", rest, 1);
    tiro(1, 0);
    chk("win_pre", vit, 0);
    tick();
    chk("win_flags", {fim, vit}, 2'b11);
    chk("win_ac", ac, 3);
    chk("win_rest", rest, 0);
    tiro(2, 2); tick(); tick();
    chk("win_ign_res", res, 1);
    chk("win_ign_ok", ok, 0);

    #3 reset_n = 1'b0;
    #1;
    chk("arst_flags", {fim, vit, ocp}, 0);
    chk("arst_vida", vida, 3);
    chk("arst_rest", rest, 0);
    chk("arst_ac", ac, 0);
    chk("arst_res", {res, lr, lg, lb, ok}, 0);
    tick();
    reset_n = 1'b1;
    est = 2'b00;

    // 8x8 grid, full map
    est8 = 2'b01; mapa8 = '1; carr8 = 1; tick(); carr8 = 0;
    chk("g8_ocp1", ocp8, 1);
    repeat (63) tick();
    chk("g8_ocp64", ocp8, 1);
    tick();
    chk("g8_fim", ocp8, 0);
    chk("g8_rest", rest8, 64);
    est8 = 2'b10; repeat (2) tick();
    lin8 = 7; col8 = 7; conf8 = 1; tick(); conf8 = 0;
    tick();
    chk("g8_hit_res", res8, 1);
    chk("g8_hit_rest", rest8, 63);
    chk("g8_hit_ac", ac8, 64'h8000_0000_0000_0000);

    est8 = 2'b01; tick();
    carr8 = 1; tick(); carr8 = 0;
    chk("g8_reload_ac", ac8, 0);
    repeat (9) tick();
    est8 = 2'b00;
    repeat (54) tick();
    chk("g8_off_ocp", ocp8, 1);
    repeat (3) tick();
    chk("g8_off_done", ocp8, 0);
    chk("g8_off_rest", rest8, 0);
    chk("g8_off_vida", vida8, 7);
    est8 = 2'b10; repeat (3) tick();
    chk("g8_off_idle", {fim8, vit8}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
